clause_writer: RTL and testbench

// - Literal-stream-to-clause packer. Drives the write side of a clause-cell array (wr/clause/clause_len).
// - Accepts one literal per handshake: variable index, polarity and last flag.
// - Packs each clause into the NUM_VARS*2 clause encoding, then issues one write pulse with a clause slot address.
// - Sits between the host/CNF loader and the clause1 array. It is the producer for the clause cells' wr_i/clause_i/clause_len_i.

---
 rtl/clause_writer.sv | 117 +++++++++++
 tb/tb_clause_writer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clause_writer.sv
// clause_writer: packs a literal stream into clause-cell words and issues one write per clause.
// Optional CLAUSE_WRITER_STATS_EN adds a saturating drop counter output.
module clause_writer #(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 4,
  parameter int IDX_W       = 3,
  parameter int ADDR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lit_valid_i,
  output logic                  lit_ready_o,
  input  logic [IDX_W-1:0]      lit_var_i,
  input  logic                  lit_neg_i,
  input  logic                  lit_last_i,
  input  logic                  clear_i,
  output logic                  wr_o,
  output logic [NUM_VARS*2-1:0] clause_o,
  output logic [4:0]            clause_len_o,
  output logic [ADDR_W-1:0]     clause_addr_o,
  output logic                  drop_o,
`ifdef CLAUSE_WRITER_STATS_EN
  output logic [7:0]            drop_cnt_o,
`endif
  output logic                  full_o
);
  typedef enum logic [1:0] {COLLECT, WRITE, FULL} state_t;
  state_t state;
  logic bad, nbad, accept;
  logic [1:0] code;
  logic [NUM_VARS*2-1:0] nbuf;
  logic [4:0] nlen;
  assign code = lit_neg_i ? 2'b10 : 2'b01;
  assign accept = lit_valid_i && lit_ready_o;
  // Buffer as it would look after accepting the current beat; out-of-range index only marks bad.
  always_comb begin
    nbuf = clause_o;
    nlen = clause_len_o;
    nbad = bad || (int'(lit_var_i) >= NUM_VARS);
    for (int i = 0; i < NUM_VARS; i++)
      if (int'(lit_var_i) == i) begin
        if (clause_o[2*i+:2] == 2'b00) begin
          nbuf[2*i+:2] = code;
          nlen = clause_len_o + 5'd1;
        end else if (clause_o[2*i+:2] != code) nbad = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= COLLECT;
      lit_ready_o   <= 1'b0;
      wr_o          <= 1'b0;
      clause_o      <= '0;
      clause_len_o  <= '0;
      clause_addr_o <= '0;
      drop_o        <= 1'b0;
      full_o        <= 1'b0;
      bad           <= 1'b0;
    end else begin
      wr_o   <= 1'b0;
      drop_o <= 1'b0;
      if (clear_i) begin
        state         <= COLLECT;
        lit_ready_o   <= 1'b1;
        clause_o      <= '0;
        clause_len_o  <= '0;
        clause_addr_o <= '0;
        full_o        <= 1'b0;
        bad           <= 1'b0;
      end else begin
        case (state)
          COLLECT: begin
            lit_ready_o <= 1'b1;
            if (accept) begin
              if (lit_last_i && nbad) begin
                drop_o       <= 1'b1;
                clause_o     <= '0;
                clause_len_o <= '0;
                bad          <= 1'b0;
              end else begin
                clause_o     <= nbuf;
                clause_len_o <= nlen;
                bad          <= nbad;
                if (lit_last_i) begin
                  state       <= WRITE;
                  wr_o        <= 1'b1;
                  lit_ready_o <= 1'b0;
                end
              end
            end
          end
          WRITE: begin
            clause_o     <= '0;
            clause_len_o <= '0;
            if (clause_addr_o == ADDR_W'(NUM_CLAUSES - 1)) begin
              state  <= FULL;
              full_o <= 1'b1;
            end else begin
              state         <= COLLECT;
              clause_addr_o <= clause_addr_o + 1'b1;
              lit_ready_o   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
`ifdef CLAUSE_WRITER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_o <= '0;
    else if (clear_i) drop_cnt_o <= '0;
    else if (state == COLLECT && accept && lit_last_i && nbad && drop_cnt_o != 8'hFF)
      drop_cnt_o <= drop_cnt_o + 8'd1;
  end
`endif
endmodule

// File: tb/tb_clause_writer.sv
// tb_clause_writer: directed and randomized clause streams checked against a clause-level model.
module tb_clause_writer;
  logic clk = 0, rst = 0;
  logic lit_valid = 0, lit_neg = 0, lit_last = 0, clear = 0;
  logic [2:0] lit_var = 0;
  logic lit_ready, wr, drop, full;
  logic [15:0] clause;
  logic [4:0] clause_len;
  logic [1:0] clause_addr;
  logic v6 = 0, neg6 = 0, last6 = 0;
  logic [2:0] var6 = 0;
  logic r6, wr6, drop6, full6;
  logic [11:0] cl6;
  logic [4:0] len6;
  logic [1:0] addr6;
`ifdef CLAUSE_WRITER_STATS_EN
  logic [7:0] drop_cnt, cnt6;
`endif

  clause_writer dut (
    .clk(clk), .rst(rst), .lit_valid_i(lit_valid), .lit_ready_o(lit_ready),
    .lit_var_i(lit_var), .lit_neg_i(lit_neg), .lit_last_i(lit_last), .clear_i(clear),
    .wr_o(wr), .clause_o(clause), .clause_len_o(clause_len), .clause_addr_o(clause_addr),
    .drop_o(drop),
`ifdef CLAUSE_WRITER_STATS_EN
    .drop_cnt_o(drop_cnt),
`endif
    .full_o(full));

  clause_writer #(.NUM_VARS(6)) u6 (
    .clk(clk), .rst(rst), .lit_valid_i(v6), .lit_ready_o(r6),
    .lit_var_i(var6), .lit_neg_i(neg6), .lit_last_i(last6), .clear_i(1'b0),
    .wr_o(wr6), .clause_o(cl6), .clause_len_o(len6), .clause_addr_o(addr6),
    .drop_o(drop6),
`ifdef CLAUSE_WRITER_STATS_EN
    .drop_cnt_o(cnt6),
`endif
    .full_o(full6));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cv[8], cn[8];
  int m_code[8];
  int m_len, m_addr, m_drops, gap_fix = -1;
  bit m_bad, m_full;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_clause();
    logic [15:0] r = 0;
    for (int v = 0; v < 8; v++) r = r | (16'(m_code[v]) << (2 * v));
    return r;
  endfunction

  task automatic beat(input int v, input bit n, input bit l);
    bit done = 0;
    lit_valid = 1; lit_var = 3'(v); lit_neg = n; lit_last = l;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      done = lit_ready;
      @(posedge clk); #1;
    end
    lit_valid = 0;
    if (!done) chk("beat_timeout", 0, 1);
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    m_addr = 0; m_full = 0; m_drops = 0;
    chk("clr_full", full, 0);
    chk("clr_addr", clause_addr, 0);
    chk("clr_ready", lit_ready, 1);
  endtask

  task automatic run_clause(input int n);
    int c;
    for (int v = 0; v < 8; v++) m_code[v] = 0;
    m_bad = 0; m_len = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap_fix >= 0 ? gap_fix : $urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      beat(cv[i], cn[i][0], i == n - 1);
      c = cn[i] ? 2 : 1;
      if (m_code[cv[i]] == 0) begin m_code[cv[i]] = c; m_len++; end
      else if (m_code[cv[i]] != c) m_bad = 1;
      if (i < n - 1) begin
        chk("part_clause", clause, exp_clause());
        chk("part_len", clause_len, m_len);
      end
    end
    if (m_bad) begin
      if (m_drops < 255) m_drops++;
      chk("drop", drop, 1);
      chk("drop_nowr", wr, 0);
      chk("drop_clause", clause, 0);
      chk("drop_len", clause_len, 0);
      chk("drop_addr", clause_addr, m_addr);
`ifdef CLAUSE_WRITER_STATS_EN
      chk("drop_cnt", drop_cnt, m_drops);
`endif
    end else begin
      chk("wr", wr, 1);
      chk("wr_nodrop", drop, 0);
      chk("wr_clause", clause, exp_clause());
      chk("wr_len", clause_len, m_len);
      chk("wr_addr", clause_addr, m_addr);
      @(posedge clk); #1;
      chk("wr_pulse", wr, 0);
      chk("post_clause", clause, 0);
      if (m_addr == 3) m_full = 1; else m_addr++;
      chk("post_full", full, m_full);
      chk("post_addr", clause_addr, m_addr);
      chk("post_ready", lit_ready, !m_full);
    end
  endtask

  initial begin
    #12;
    chk("rst_wr", wr, 0); chk("rst_ready", lit_ready, 0); chk("rst_full", full, 0);
    chk("rst_clause", clause, 0); chk("rst_len", clause_len, 0);
    chk("rst_addr", clause_addr, 0); chk("rst_drop", drop, 0);
    @(posedge clk); #1;
    rst = 1;
    m_addr = 0; m_full = 0; m_drops = 0;
    chk("rel_ready0", lit_ready, 0);
    @(posedge clk); #1;
    chk("rel_ready1", lit_ready, 1);
    // basic write
    cv[0] = 1; cn[0] = 0; cv[1] = 3; cn[1] = 1; cv[2] = 5; cn[2] = 1;
    gap_fix = 0;
    run_clause(3);
    do_clear();
    // tautology, then the next clause still lands in slot 0
    cv[0] = 2; cn[0] = 0; cv[1] = 2; cn[1] = 1;
    run_clause(2);
    gap_fix = 3;
    cv[0] = 4; cn[0] = 0; cv[1] = 4; cn[1] = 0;
    run_clause(2);
    gap_fix = -1;
    do_clear();
    // fill all slots
    for (int s = 0; s < 4; s++) begin
      cv[0] = s + 2; cn[0] = s & 1;
      run_clause(1);
    end
    lit_valid = 1; lit_var = 3'd2; lit_neg = 0; lit_last = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("full_held_ready", lit_ready, 0);
    chk("full_held_wr", wr, 0);
    chk("full_held_len", clause_len, 0);
    chk("full_held_addr", clause_addr, 3);
    lit_valid = 0;
    do_clear();
    cv[0] = 6; cn[0] = 1;
    run_clause(1);
    // clear beats a simultaneous literal
    beat(2, 0, 0);
    clear = 1; lit_valid = 1; lit_var = 3'd4; lit_last = 0;
    @(posedge clk); #1;
    clear = 0; lit_valid = 0;
    m_addr = 0; m_full = 0; m_drops = 0;
    chk("clrbeat_len", clause_len, 0);
    chk("clrbeat_clause", clause, 0);
    chk("clrbeat_addr", clause_addr, 0);
    // reset mid-clause
    beat(0, 0, 0);
    rst = 0;
    #1;
    chk("mid_rst_len", clause_len, 0);
    chk("mid_rst_clause", clause, 0);
    @(posedge clk); #1;
    rst = 1;
    m_addr = 0; m_full = 0; m_drops = 0;
    cv[0] = 7; cn[0] = 1;
    run_clause(1);
    // bad index on a 6-variable writer
    v6 = 1; var6 = 3'd6; neg6 = 0; last6 = 1;
    @(negedge clk);
    chk("bad_ready", r6, 1);
    @(posedge clk); #1;
    v6 = 0;
    chk("bad_drop", drop6, 1);
    chk("bad_nowr", wr6, 0);
    chk("bad_len", len6, 0);
    v6 = 1; var6 = 3'd5; neg6 = 0; last6 = 1;
    @(posedge clk); #1;
    v6 = 0;
    chk("v6_wr", wr6, 1);
    chk("v6_clause", cl6, 12'h400);
    chk("v6_addr", addr6, 0);
    // randomized clauses
    do_clear();
    for (int t = 0; t < 60; t++) begin
      if (m_full || $urandom_range(0, 9) == 0) do_clear();
      begin
        int n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) begin
          cv[i] = $urandom_range(0, 7);
          cn[i] = $urandom_range(0, 1);
        end
        run_clause(n);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
